// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG pixel path: colour indices, cell mode decode and the
// captured-cell record that travels from the hold register into the expander.
package vdg_pkg;

    localparam int DEF_FONT_ROWS = 12;

    localparam logic [3:0] COL_GREEN    = 4'd0;
    localparam logic [3:0] COL_BUFF     = 4'd4;
    localparam logic [3:0] COL_ORANGE   = 4'd7;
    localparam logic [3:0] COL_BLACK    = 4'd8;
    localparam logic [3:0] COL_DKGREEN  = 4'd9;
    localparam logic [3:0] COL_DKORANGE = 4'd10;

    typedef enum logic [2:0] {
        MODE_ALPHA,
        MODE_SG4,
        MODE_SG6,
        MODE_CG,
        MODE_RG
    } cellMode_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        cellMode_t  mode;
        logic       css;
        logic       inv;
        logic [3:0] row;
    } holdCell_t;

    // Mode is resolved once at load so the expander only ever sees one of five cases
    function automatic cellMode_t decodeMode(input logic ang, input logic rgSel,
                                             input logic sgSel, input logic sg6Sel);
        cellMode_t m;
        if (ang)
            m = rgSel ? MODE_RG : MODE_CG;
        else if (sgSel)
            m = sg6Sel ? MODE_SG6 : MODE_SG4;
        else
            m = MODE_ALPHA;
        return m;
    endfunction

endpackage

// File: rtl/vdg_font_rom.sv
// Internal 64-character font: 5x7 glyphs placed in rows 3..9 of a 12-row, 8-pixel cell.
// Purely combinational, addressed by {character code, scanline}.
module vdg_font_rom (
    input  logic [9:0] addr,
    output logic [7:0] bits
);

    logic [34:0] glyph;
    logic [4:0]  rowBits;

    always_comb begin
        glyph = '0;
        case (addr[9:4])
            6'h00: glyph = {5'h0E, 5'h11, 5'h01, 5'h0D, 5'h15, 5'h15, 5'h0E};
            6'h01: glyph = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            6'h02: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
            6'h03: glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
            6'h04: glyph = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
            6'h05: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
            6'h06: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
            6'h07: glyph = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
            6'h08: glyph = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            6'h09: glyph = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            6'h0A: glyph = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
            6'h0B: glyph = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
            6'h0C: glyph = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
            6'h0D: glyph = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
            6'h0E: glyph = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
            6'h0F: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            6'h10: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
            6'h11: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
            6'h12: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
            6'h13: glyph = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
            6'h14: glyph = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
            6'h15: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            6'h16: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            6'h17: glyph = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
            6'h18: glyph = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
            6'h19: glyph = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
            6'h1A: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
            6'h1B: glyph = {5'h0E, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h0E};
            6'h1C: glyph = {5'h00, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00};
            6'h1D: glyph = {5'h0E, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0E};
            6'h1E: glyph = {5'h04, 5'h0E, 5'h15, 5'h04, 5'h04, 5'h04, 5'h04};
            6'h1F: glyph = {5'h00, 5'h04, 5'h08, 5'h1F, 5'h08, 5'h04, 5'h00};
            6'h20: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
            6'h21: glyph = {5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00, 5'h04};
            6'h22: glyph = {5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00};
            6'h23: glyph = {5'h0A, 5'h0A, 5'h1F, 5'h0A, 5'h1F, 5'h0A, 5'h0A};
            6'h24: glyph = {5'h04, 5'h0F, 5'h14, 5'h0E, 5'h05, 5'h1E, 5'h04};
            6'h25: glyph = {5'h18, 5'h19, 5'h02, 5'h04, 5'h08, 5'h13, 5'h03};
            6'h26: glyph = {5'h0C, 5'h12, 5'h14, 5'h08, 5'h15, 5'h12, 5'h0D};
            6'h27: glyph = {5'h0C, 5'h04, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00};
            6'h28: glyph = {5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02};
            6'h29: glyph = {5'h08, 5'h04, 5'h02, 5'h02, 5'h02, 5'h04, 5'h08};
            6'h2A: glyph = {5'h00, 5'h04, 5'h15, 5'h0E, 5'h15, 5'h04, 5'h00};
            6'h2B: glyph = {5'h00, 5'h04, 5'h04, 5'h1F, 5'h04, 5'h04, 5'h00};
            6'h2C: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h04, 5'h08};
            6'h2D: glyph = {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
            6'h2E: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C};
            6'h2F: glyph = {5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00};
            6'h30: glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            6'h31: glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            6'h32: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            6'h33: glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            6'h34: glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            6'h35: glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            6'h36: glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            6'h37: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            6'h38: glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            6'h39: glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            6'h3A: glyph = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
            6'h3B: glyph = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h04, 5'h08};
            6'h3C: glyph = {5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02};
            6'h3D: glyph = {5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00};
            6'h3E: glyph = {5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04, 5'h08};
            6'h3F: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h00, 5'h04};
            default: glyph = '0;
        endcase
    end

    // Rows 0-2 and 10-11 are the inter-character spacing and always read blank
    always_comb begin
        rowBits = '0;
        case (addr[3:0])
            4'd3:    rowBits = glyph[34:30];
            4'd4:    rowBits = glyph[29:25];
            4'd5:    rowBits = glyph[24:20];
            4'd6:    rowBits = glyph[19:15];
            4'd7:    rowBits = glyph[14:10];
            4'd8:    rowBits = glyph[9:5];
            4'd9:    rowBits = glyph[4:0];
            default: rowBits = '0;
        endcase
    end

    assign bits = {2'b00, rowBits, 1'b0};

endmodule

// File: rtl/vdg_pixel_shifter.sv
// Pixel serialiser: each load captures a display byte with its mode, expands the previously
// captured byte into 8 colour indices and shifts them out one per pixel tick.
module vdg_pixel_shifter
    import vdg_pkg::*;
#(
    parameter int         FONT_ROWS = DEF_FONT_ROWS,
    parameter logic [3:0] BLACK_IDX = COL_BLACK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       load,
    input  logic       active,
    input  logic [7:0] data,
    input  logic       ang,
    input  logic [2:0] gmode,
    input  logic       as,
    input  logic       int_ext,
    input  logic       inv,
    input  logic       css,
    input  logic [3:0] alpha_row,
    output logic [3:0] pixel,
    output logic       pix_valid
);

    holdCell_t   hold;
    logic [31:0] shiftReg;
    logic [31:0] cellPixels;
    logic        shiftValid;
    logic [2:0]  tickCnt;
    logic [7:0]  fontBits;
    logic [7:0]  glyph;
    logic        rowBlank;
    logic        sgLeft;
    logic        sgRight;
    logic [3:0]  sgColour;
    logic [3:0]  fgColour;
    logic [3:0]  bgColour;
    logic [3:0]  borderColour;
    logic        unusedGmode;

    assign unusedGmode  = ^gmode[2:1];
    assign rowBlank     = (int'(hold.row) >= FONT_ROWS);
    assign borderColour = ang ? (css ? COL_BUFF : COL_GREEN) : BLACK_IDX;

    vdg_font_rom uFont (
        .addr ({hold.data[5:0], hold.row}),
        .bits (fontBits)
    );

    // Expand the held cell into 8 nibbles; slot 7 (bits 31:28) is the leftmost pixel
    always_comb begin
        cellPixels = {8{BLACK_IDX}};
        glyph      = fontBits ^ {8{hold.inv}};
        fgColour   = hold.css ? COL_ORANGE : COL_GREEN;
        bgColour   = hold.css ? COL_DKORANGE : COL_DKGREEN;
        sgColour   = {1'b0, hold.data[6:4]};
        sgLeft     = 1'b0;
        sgRight    = 1'b0;
        case (hold.mode)
            MODE_ALPHA: begin
                for (int i = 0; i < 8; i++)
                    cellPixels[4*i +: 4] = (glyph[i] && !rowBlank) ? fgColour : bgColour;
            end
            MODE_SG4, MODE_SG6: begin
                if (hold.mode == MODE_SG4) begin
                    sgLeft  = (hold.row < 4'd6) ? hold.data[3] : hold.data[1];
                    sgRight = (hold.row < 4'd6) ? hold.data[2] : hold.data[0];
                end else begin
                    sgColour = {1'b0, hold.css, hold.data[7:6]};
                    case (hold.row[3:2])
                        2'd0:    {sgLeft, sgRight} = hold.data[5:4];
                        2'd1:    {sgLeft, sgRight} = hold.data[3:2];
                        default: {sgLeft, sgRight} = hold.data[1:0];
                    endcase
                end
                for (int i = 0; i < 8; i++)
                    cellPixels[4*i +: 4] = (((i >= 4) ? sgLeft : sgRight) && !rowBlank)
                                           ? sgColour : BLACK_IDX;
            end
            MODE_CG: begin
                for (int i = 0; i < 8; i++)
                    cellPixels[4*i +: 4] = {1'b0, hold.css, hold.data[2*(i/2) +: 2]};
            end
            MODE_RG: begin
                for (int i = 0; i < 8; i++)
                    cellPixels[4*i +: 4] = hold.data[i] ? (hold.css ? COL_BUFF : COL_GREEN)
                                                        : BLACK_IDX;
            end
            default: ;
        endcase
    end

    // Cell pipeline: load moves hold into the shifter and recaptures hold from the inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            shiftReg   <= '0;
            shiftValid <= 1'b0;
            tickCnt    <= 3'd0;
        end else if (pix_en) begin
            if (load) begin
                shiftReg   <= cellPixels;
                shiftValid <= hold.valid;
                tickCnt    <= 3'd0;
                hold.valid <= 1'b1;
                hold.data  <= data;
                hold.mode  <= decodeMode(ang, gmode[0], as, int_ext);
                hold.css   <= css;
                hold.inv   <= inv;
                hold.row   <= alpha_row;
            end else begin
                shiftReg <= {shiftReg[27:0], 4'h0};
                tickCnt  <= tickCnt + 3'd1;
                if (tickCnt == 3'd7)
                    shiftValid <= 1'b0;
            end
        end
    end

    // Registered output; an empty shifter or the border region both show the border colour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel     <= BLACK_IDX;
            pix_valid <= 1'b0;
        end else if (pix_en) begin
            if (active && shiftValid) begin
                pixel     <= shiftReg[31:28];
                pix_valid <= 1'b1;
            end else begin
                pixel     <= borderColour;
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdg_pixel_shifter.sv
// Self-checking bench for vdg_pixel_shifter: directed cells from the mode tables, then
// randomized traffic, all compared against a cell-level reference model.
module tb_vdg_pixel_shifter;

    localparam logic [3:0] GREEN = 4'd0, BUFF = 4'd4, ORANGE = 4'd7;
    localparam logic [3:0] BLACK = 4'd8, DKGRN = 4'd9, DKORG = 4'd10;

    logic       clk = 1'b0;
    logic       reset, pix_en, load, active, ang, as, int_ext, inv, css;
    logic [7:0] data;
    logic [2:0] gmode;
    logic [3:0] alpha_row, pixel;
    logic       pix_valid;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: the cell on screen as 8 colours, and the captured-but-not-shown byte
    logic [3:0] cellPix [8];
    bit         cellLoaded;
    int         ticksShown;
    bit         holdLoaded;
    logic [7:0] hData;
    logic       hAng, hG0, hAs, hExt, hInv, hCss;
    logic [3:0] hRow;
    logic [3:0] expPixel;
    logic       expValid;

    logic [4:0] letterAt [7] = '{5'h0E, 5'h11, 5'h01, 5'h0D, 5'h15, 5'h15, 5'h0E};
    logic [4:0] letterA  [7] = '{5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};

    always #5 clk = ~clk;

    vdg_pixel_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .load      (load),
        .active    (active),
        .data      (data),
        .ang       (ang),
        .gmode     (gmode),
        .as        (as),
        .int_ext   (int_ext),
        .inv       (inv),
        .css       (css),
        .alpha_row (alpha_row),
        .pixel     (pixel),
        .pix_valid (pix_valid)
    );

    // Only '@' and 'A' glyph rows are known here; other codes are only used on blank rows
    function automatic logic [7:0] fontModel(input logic [5:0] code, input int row);
        if (row < 3 || row > 9) return 8'h00;
        if (code == 6'h00) return {2'b00, letterAt[row-3], 1'b0};
        if (code == 6'h01) return {2'b00, letterA[row-3], 1'b0};
        return 8'h00;
    endfunction

    task automatic computeCell();
        logic [7:0] g;
        logic [3:0] colour;
        logic       l, r;
        int         band;
        for (int i = 0; i < 8; i++) cellPix[i] = BLACK;
        if (hAng) begin
            for (int i = 0; i < 8; i++) begin
                if (hG0)
                    cellPix[i] = hData[7-i] ? (hCss ? BUFF : GREEN) : BLACK;
                else
                    cellPix[i] = {1'b0, hCss, 2'((hData >> (6 - 2*(i/2))) & 8'h03)};
            end
        end else if (hRow >= 4'd12) begin
            for (int i = 0; i < 8; i++) cellPix[i] = hAs ? BLACK : (hCss ? DKORG : DKGRN);
        end else if (!hAs) begin
            g = fontModel(hData[5:0], int'(hRow)) ^ (hInv ? 8'hFF : 8'h00);
            for (int i = 0; i < 8; i++)
                cellPix[i] = g[7-i] ? (hCss ? ORANGE : GREEN) : (hCss ? DKORG : DKGRN);
        end else begin
            if (!hExt) begin
                colour = {1'b0, hData[6:4]};
                l = (hRow < 4'd6) ? hData[3] : hData[1];
                r = (hRow < 4'd6) ? hData[2] : hData[0];
            end else begin
                band = int'(hRow) / 4;
                colour = {1'b0, hCss, hData[7:6]};
                l = hData[5 - 2*band];
                r = hData[4 - 2*band];
            end
            for (int i = 0; i < 8; i++) cellPix[i] = ((i < 4) ? l : r) ? colour : BLACK;
        end
    endtask

    task automatic modelReset();
        cellLoaded = 0;
        holdLoaded = 0;
        ticksShown = 0;
        expPixel   = BLACK;
        expValid   = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        nCompared++;
        assert (pixel === expPixel) else begin
            nMismatched++;
            $error("[TB] FAIL %s pixel: observed %0d expected %0d", tag, pixel, expPixel);
        end
        nCompared++;
        assert (pix_valid === expValid) else begin
            nMismatched++;
            $error("[TB] FAIL %s pix_valid: observed %0b expected %0b", tag, pix_valid, expValid);
        end
    endtask

    // One pixel tick, then an idle dot clock with scrambled inputs that must be ignored
    task automatic applyStimulus(input bit ld, input logic [7:0] d, input string tag);
        logic [16:0] saved;
        @(negedge clk);
        load = ld;
        data = d;
        pix_en = 1'b1;
        if (active && cellLoaded && ticksShown < 8) begin
            expPixel = cellPix[ticksShown];
            expValid = 1'b1;
        end else begin
            expPixel = ang ? (css ? BUFF : GREEN) : BLACK;
            expValid = 1'b0;
        end
        if (ld) begin
            computeCell();
            cellLoaded = holdLoaded;
            ticksShown = 0;
            holdLoaded = 1;
            {hData, hAng, hG0, hAs, hExt, hInv, hCss, hRow} =
                {d, ang, gmode[0], as, int_ext, inv, css, alpha_row};
        end else if (ticksShown < 8) begin
            ticksShown++;
        end
        @(posedge clk);
        #1;
        saved = {ang, gmode, as, int_ext, inv, css, alpha_row, active, 4'h0};
        pix_en = 1'b0;
        load = 1'($urandom);
        data = 8'($urandom);
        {ang, gmode, as, int_ext, inv, css, alpha_row, active} = 13'($urandom);
        @(posedge clk);
        #1;
        checkOutput(tag);
        {ang, gmode, as, int_ext, inv, css, alpha_row, active} = saved[16:4];
    endtask

    task automatic cellRun(input logic [7:0] d, input int ticks, input string tag);
        applyStimulus(1'b1, d, tag);
        for (int t = 1; t < ticks; t++) applyStimulus(1'b0, 8'($urandom), tag);
    endtask

    initial begin
        reset = 1'b1;
        pix_en = 1'b0; load = 1'b0; active = 1'b1; data = 8'h00;
        ang = 1'b0; gmode = 3'd0; as = 1'b0; int_ext = 1'b0; inv = 1'b0; css = 1'b0;
        alpha_row = 4'd0;
        modelReset();
        #2;
        checkOutput("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // RG css=0: A5 then 00; A5 shows as 0,8,0,8,8,0,8,0
        ang = 1'b1; gmode = 3'b001; css = 1'b0;
        cellRun(8'hA5, 8, "rg_a5");
        cellRun(8'h00, 8, "rg_00");
        // CG css=1: 00_01_10_11 shows as 4,4,5,5,6,6,7,7
        gmode = 3'b000; css = 1'b1;
        cellRun(8'b00_01_10_11, 8, "cg_ramp");
        // Alpha inverted blank row, then row past the font
        ang = 1'b0; as = 1'b0; inv = 1'b1; css = 1'b0; alpha_row = 4'd0;
        cellRun(8'h00, 8, "alpha_row0");
        alpha_row = 4'd13;
        cellRun(8'h00, 8, "alpha_row13");
        // Alpha glyph row from 'A', orange set
        inv = 1'b0; css = 1'b1; alpha_row = 4'd6;
        cellRun(8'h01, 8, "alpha_A");
        // SG4 rows 2 and 8
        as = 1'b1; int_ext = 1'b0; css = 1'b0; alpha_row = 4'd2;
        cellRun(8'b1_011_1010, 8, "sg4_row2");
        alpha_row = 4'd8;
        cellRun(8'b1_011_1010, 8, "sg4_row8");
        // SG6 middle band, then truncated cells
        int_ext = 1'b1; css = 1'b1; alpha_row = 4'd5;
        cellRun(8'b10_01_10_11, 8, "sg6_row5");
        ang = 1'b1; gmode = 3'b001;
        cellRun(8'hF0, 3, "trunc_a");
        cellRun(8'h3C, 5, "trunc_b");
        // Starvation after one load, then border with active=0 in both colour sets
        cellRun(8'hC3, 10, "starve");
        cellRun(8'h99, 10, "starve2");
        active = 1'b0; css = 1'b1;
        applyStimulus(1'b0, 8'h00, "border_buff");
        ang = 1'b0;
        applyStimulus(1'b0, 8'h00, "border_black");
        // Active low over a live cell: pipeline keeps moving underneath
        ang = 1'b1; css = 1'b0;
        cellRun(8'h81, 8, "act_prep");
        applyStimulus(1'b1, 8'h00, "act_load");
        applyStimulus(1'b0, 8'h00, "act_off");
        applyStimulus(1'b0, 8'h00, "act_off");
        active = 1'b1;
        for (int t = 0; t < 6; t++) applyStimulus(1'b0, 8'h00, "act_on");

        // Mid-cell async reset with FF in the shifter; hold must be cleared too
        cellRun(8'hFF, 8, "rst_prep");
        cellRun(8'h00, 3, "rst_mid");
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_async");
        @(negedge clk);
        reset = 1'b0;
        cellRun(8'h5A, 8, "rst_after");
        cellRun(8'h00, 8, "rst_after2");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic       ld;
            logic [7:0] d;
            {ang, gmode, as, int_ext, inv, css} = 8'($urandom);
            active = ($urandom_range(0, 7) != 0);
            d = 8'($urandom);
            alpha_row = 4'($urandom);
            if (!ang && !as) begin
                if ($urandom_range(0, 1) == 1) d[5:0] = 6'($urandom_range(0, 1));
                if (d[5:0] > 6'd1) alpha_row = 4'($urandom_range(0, 8));
                if (alpha_row > 4'd2) alpha_row = alpha_row + 4'd7;
            end
            if (ticksShown >= 7) ld = ($urandom_range(0, 3) != 0);
            else                 ld = ($urandom_range(0, 9) == 0);
            applyStimulus(ld, d, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
